// File: rtl/reset_seq_pkg.sv
// reset_seq_pkg: shared types for the reset sequencer.
// States, cause codes and a sizing helper.
package reset_seq_pkg;

  typedef enum logic [1:0] {
    S_LOCK,
    S_HOLD,
    S_REL,
    S_RUN
  } state_t;

  localparam logic [1:0] CAUSE_POR  = 2'b00;
  localparam logic [1:0] CAUSE_LOCK = 2'b01;
  localparam logic [1:0] CAUSE_SW   = 2'b10;

  function automatic int max3(
    input int a,
    input int b,
    input int c
  );
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/sync_bit.sv
// sync_bit: multi-flop single-bit synchroniser.
// Clears to 0 asynchronously on reset.
module sync_bit #(
  parameter int STAGES = 2
) (
  input  logic clock,
  input  logic reset,
  input  logic d,
  output logic q
);

  if (STAGES < 2) begin : g_bad_stages
    $error("sync_bit: STAGES must be >= 2");
  end

  logic [STAGES-1:0] ff;

  // shift the async input through the flop chain
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      ff <= '0;
    end else begin
      ff <= {ff[STAGES-2:0], d};
    end
  end

  assign q = ff[STAGES-1];

endmodule

// File: rtl/reset_sequencer.sv
// reset_sequencer: qualifies PLL lock, holds, then
// releases reset domains in staggered order.
module reset_sequencer
  import reset_seq_pkg::*;
#(
  parameter int N_OUT          = 2,
  parameter int HOLD_CYCLES    = 128,
  parameter int STAGGER_CYCLES = 16,
  parameter int LOCK_FILTER    = 64,
  parameter int SYNC_STAGES    = 2
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             pll_lock,
  input  logic             sw_req,
  output logic [N_OUT-1:0] rst_out,
  output logic             all_ready,
  output logic [1:0]       cause
);

  if (N_OUT < 1) begin : g_bad_n
    $error("reset_sequencer: N_OUT must be >= 1");
  end
  if (HOLD_CYCLES < 1) begin : g_bad_hold
    $error("reset_sequencer: HOLD_CYCLES must be >= 1");
  end
  if (STAGGER_CYCLES < 1) begin : g_bad_stag
    $error("reset_sequencer: STAGGER_CYCLES must be >= 1");
  end
  if (LOCK_FILTER < 1) begin : g_bad_filt
    $error("reset_sequencer: LOCK_FILTER must be >= 1");
  end
  if (SYNC_STAGES < 2) begin : g_bad_sync
    $error("reset_sequencer: SYNC_STAGES must be >= 2");
  end

  localparam int REL_END = (N_OUT - 1) * STAGGER_CYCLES;
  localparam int CW =
    $clog2(max3(LOCK_FILTER, HOLD_CYCLES, REL_END + 1)) + 1;

  localparam logic [CW-1:0] LF_LAST   = CW'(LOCK_FILTER - 1);
  localparam logic [CW-1:0] HOLD_LAST = CW'(HOLD_CYCLES - 1);
  localparam logic [CW-1:0] REL_LAST  = CW'(REL_END);

  logic          lock_s;
  state_t        state;
  logic [CW-1:0] cnt;

  sync_bit #(
    .STAGES(SYNC_STAGES)
  ) u_lock_sync (
    .clock(clock),
    .reset(reset),
    .d    (pll_lock),
    .q    (lock_s)
  );

  // sequencer FSM with its counter and registered outputs
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state     <= S_LOCK;
      cnt       <= '0;
      rst_out   <= '1;
      all_ready <= 1'b0;
      cause     <= CAUSE_POR;
    end else if (state != S_LOCK && !lock_s) begin
      state     <= S_LOCK;
      cnt       <= '0;
      rst_out   <= '1;
      all_ready <= 1'b0;
      cause     <= CAUSE_LOCK;
    end else if (state != S_LOCK && sw_req) begin
      state     <= S_HOLD;
      cnt       <= '0;
      rst_out   <= '1;
      all_ready <= 1'b0;
      cause     <= CAUSE_SW;
    end else begin
      unique case (state)
        S_LOCK: begin
          rst_out   <= '1;
          all_ready <= 1'b0;
          if (!lock_s) begin
            cnt <= '0;
          end else if (cnt == LF_LAST) begin
            state <= S_HOLD;
            cnt   <= '0;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        S_HOLD: begin
          if (cnt == HOLD_LAST) begin
            state <= S_REL;
            cnt   <= '0;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        S_REL: begin
          for (int i = 0; i < N_OUT; i++) begin
            if (cnt == CW'(i * STAGGER_CYCLES))
              rst_out[i] <= 1'b0;
          end
          if (cnt == REL_LAST) begin
            state <= S_RUN;
            cnt   <= '0;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        S_RUN: begin
          rst_out   <= '0;
          all_ready <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_reset_sequencer.sv
// tb_reset_sequencer: directed scoreboard bench
// for the default-parameter reset sequencer.
module tb_reset_sequencer;
  import reset_seq_pkg::*;

  typedef struct {
    int         at;
    logic [1:0] r;
    logic       a;
    logic [1:0] c;
  } ev_t;

  logic       clock;
  logic       reset;
  logic       pll_lock;
  logic       sw_req;
  logic [1:0] rst_out;
  logic       all_ready;
  logic [1:0] cause;

  int   cyc;
  int   tests;
  int   fails;
  ev_t  sbq[$];
  logic [4:0] cur;
  logic [4:0] prev;

  reset_sequencer dut (
    .clock    (clock),
    .reset    (reset),
    .pll_lock (pll_lock),
    .sw_req   (sw_req),
    .rst_out  (rst_out),
    .all_ready(all_ready),
    .cause    (cause)
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  // edges since the last reset release
  always @(posedge clock) begin
    if (reset) cyc <= 0;
    else cyc <= cyc + 1;
  end

  task automatic push(
    input int at, input logic [1:0] r,
    input logic a, input logic [1:0] c
  );
    ev_t e;
    e.at = at;
    e.r  = r;
    e.a  = a;
    e.c  = c;
    sbq.push_back(e);
  endtask

  task automatic wait_edge(input int n);
    do begin
      @(posedge clock);
      #1;
    end while (cyc < n);
  endtask

  task automatic chk(
    input string nm, input logic [4:0] got,
    input logic [4:0] exp
  );
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s got %b required %b", nm, got, exp);
    end
  endtask

  // monitor: each output change pops one expected event
  always @(negedge clock) begin
    ev_t e;
    cur = {rst_out, all_ready, cause};
    if (reset) begin
      prev = cur;
    end else if (cur !== prev) begin
      prev = cur;
      tests++;
      if (sbq.size() == 0) begin
        fails++;
        $display("FAIL unexpected_event edge %0d got %b",
                 cyc, cur);
      end else begin
        e = sbq.pop_front();
        if (e.at != cyc || cur !== {e.r, e.a, e.c}) begin
          fails++;
          $display(
            "FAIL event got edge %0d %b required edge %0d %b",
            cyc, cur, e.at, {e.r, e.a, e.c});
        end
      end
    end
  end

  initial begin
    tests    = 0;
    fails    = 0;
    pll_lock = 1'b1;
    sw_req   = 1'b0;
    reset    = 1'b0;
    #1 reset = 1'b1;
    #1 chk("por_state", {rst_out, all_ready, cause},
           {2'b11, 1'b0, CAUSE_POR});

    // power-on: T0 = 2 + 64 + 128 + 1
    push(195, 2'b10, 1'b0, CAUSE_POR);
    push(211, 2'b00, 1'b0, CAUSE_POR);
    push(212, 2'b00, 1'b1, CAUSE_POR);
    @(negedge clock);
    @(negedge clock);
    reset = 1'b0;

    // lock loss: drop after 300, seen at 300+2+1
    wait_edge(300);
    pll_lock = 1'b0;
    push(303, 2'b11, 1'b0, CAUSE_LOCK);
    wait_edge(310);
    pll_lock = 1'b1;
    // relock acts like power-on shifted by 310
    push(505, 2'b10, 1'b0, CAUSE_LOCK);
    push(521, 2'b00, 1'b0, CAUSE_LOCK);
    push(522, 2'b00, 1'b1, CAUSE_LOCK);

    // software request sampled at 601
    wait_edge(600);
    sw_req = 1'b1;
    push(601, 2'b11, 1'b0, CAUSE_SW);
    wait_edge(601);
    sw_req = 1'b0;
    push(730, 2'b10, 1'b0, CAUSE_SW);
    push(746, 2'b00, 1'b0, CAUSE_SW);
    push(747, 2'b00, 1'b1, CAUSE_SW);

    // sw_req on the same edge lock_s is first low
    wait_edge(800);
    pll_lock = 1'b0;
    wait_edge(802);
    sw_req = 1'b1;
    push(803, 2'b11, 1'b0, CAUSE_LOCK);
    wait_edge(803);
    sw_req = 1'b0;
    wait_edge(810);
    pll_lock = 1'b1;
    // full lock filter again proves S_LOCK was entered
    push(1005, 2'b10, 1'b0, CAUSE_LOCK);

    // async reset in S_REL while rst_out = 10
    wait_edge(1010);
    #2 reset = 1'b1;
    #1 chk("async_reset", {rst_out, all_ready, cause},
           {2'b11, 1'b0, CAUSE_POR});
    push(195, 2'b10, 1'b0, CAUSE_POR);
    push(211, 2'b00, 1'b0, CAUSE_POR);
    push(212, 2'b00, 1'b1, CAUSE_POR);
    repeat (3) @(negedge clock);
    reset = 1'b0;

    // lock glitch at edge 40: lock_s high again
    // from edge 44 instead of 3, so +41
    wait_edge(220);
    #2 reset = 1'b1;
    push(236, 2'b10, 1'b0, CAUSE_POR);
    push(252, 2'b00, 1'b0, CAUSE_POR);
    push(253, 2'b00, 1'b1, CAUSE_POR);
    repeat (3) @(negedge clock);
    reset = 1'b0;
    wait_edge(40);
    pll_lock = 1'b0;
    wait_edge(41);
    pll_lock = 1'b1;

    for (int i = 0; i < 400 && sbq.size() > 0; i++)
      @(posedge clock);
    @(negedge clock);
    #1;
    while (sbq.size() > 0) begin
      ev_t e;
      e = sbq.pop_front();
      tests++;
      fails++;
      $display("FAIL missing_event got none required edge %0d %b",
               e.at, {e.r, e.a, e.c});
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
